// File: rtl/pe_namespace_pkg.sv
// Shared encodings for the PE memory namespace: bus namespace codes, control
// states and the bus-word count that makes up one instruction.
package pe_namespace_pkg;

    typedef enum logic [1:0] {
        NS_INST   = 2'd0,
        NS_DATA   = 2'd1,
        NS_WEIGHT = 2'd2,
        NS_META   = 2'd3
    } ns_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int words_per_inst(input int inst_len, input int word_len);
        return (inst_len + word_len - 1) / word_len;
    endfunction

    localparam int INST_LEN     = 69;
    localparam int MEM_DATA_LEN = 16;
    localparam int INST_WORDS   = words_per_inst(INST_LEN, MEM_DATA_LEN);

endpackage

// File: rtl/pe_namespace_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port that
// returns the old contents when reading the address being written.
module pe_namespace_ram #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // NOTE: the storage array has no reset so it maps onto block RAM; only the
    // read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset)      rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pe_namespace.sv
// Per-PE memory namespace: loads instruction/data/weight/meta memories from the
// shared bus, feeds the PE core, and writes the weights back after eoc.
module pe_namespace
    import pe_namespace_pkg::*;
#(
    parameter int peId             = 0,
    parameter int logNumPe         = 3,
    parameter int memIndexLen      = 6,
    parameter int instAddrLen      = 5,
    parameter int dataAddrLen      = 5,
    parameter int weightAddrLen    = 5,
    parameter int metaAddrLen      = 2,
    parameter int dataLen          = 16,
    parameter int instLen          = INST_LEN,
    parameter int logMemNamespaces = 2,
    parameter int memDataLen       = MEM_DATA_LEN
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        mem_wrt_valid,
    input  logic [logNumPe-1:0]         peId_mem_in,
    input  logic [logMemNamespaces-1:0] mem_data_type,
    inout  wire  [memDataLen-1:0]       mem_data_inout,
    input  logic                        pe_core_inst_eoc,
    output logic                        mem_wrt_back,
    output logic                        pe_namespace_wrt_done,
    input  logic                        pe_core_inst_stall,
    input  logic                        pe_core_inst_eol,
    input  logic [dataAddrLen-1:0]      pe_core_data_rd_addr,
    input  logic [weightAddrLen-1:0]    pe_core_weight_wrt_addr,
    input  logic                        pe_core_weight_wrt,
    input  logic [dataLen-1:0]          pe_core_weight_wrt_data,
    input  logic [weightAddrLen-1:0]    pe_core_weight_rd_addr,
    input  logic [weightAddrLen-1:0]    pe_core_gradient_wrt_addr,
    input  logic                        pe_core_gradient_wrt,
    input  logic [dataLen-1:0]          pe_core_gradient_wrt_data,
    input  logic [weightAddrLen-1:0]    pe_core_gradient_rd_addr,
    input  logic [metaAddrLen-1:0]      pe_core_meta_rd_addr,
    output logic [instLen-1:0]          pe_namespace_inst_out,
    output logic                        pe_namespace_inst_valid,
    output logic [dataLen-1:0]          pe_namespace_data_out,
    output logic                        pe_namespace_data_out_v,
    output logic [dataLen-1:0]          pe_namespace_weight_out,
    output logic                        pe_namespace_weight_out_v,
    output logic [dataLen-1:0]          pe_namespace_gradient_out,
    output logic                        pe_namespace_gradient_out_v,
    output logic [dataLen-1:0]          pe_namespace_meta_out,
    output logic                        pe_namespace_meta_out_v
);

    localparam int BUF_W        = (INST_WORDS - 1) * memDataLen;
    localparam int LAST_W       = instLen - BUF_W;
    localparam int WEIGHT_DEPTH = 2 ** weightAddrLen;

    state_e                   state_q, state_d;
    logic                     running, fetch, accept;
    logic                     ld_inst, ld_data, ld_weight, ld_meta, inst_wr, wb_last;
    logic [instAddrLen-1:0]   pc, inst_ptr;
    logic [dataAddrLen-1:0]   data_ptr;
    logic [weightAddrLen-1:0] weight_ptr;
    logic [metaAddrLen-1:0]   meta_ptr;
    logic [2:0]               word_cnt;
    logic [BUF_W-1:0]         inst_buf;
    logic [memIndexLen-1:0]   wb_cnt;
    logic                     weight_wr_en;
    logic [weightAddrLen-1:0] weight_wr_addr, weight_rd_addr;
    logic [dataLen-1:0]       weight_wr_data, weight_rd_data;

    assign running   = (state_q == ST_RUN);
    assign fetch     = running && !pe_core_inst_stall;
    assign accept    = mem_wrt_valid && (peId_mem_in == logNumPe'(peId)) && !mem_wrt_back;
    assign ld_inst   = accept && (mem_data_type == NS_INST);
    assign ld_data   = accept && (mem_data_type == NS_DATA);
    assign ld_weight = accept && (mem_data_type == NS_WEIGHT);
    assign ld_meta   = accept && (mem_data_type == NS_META);
    assign inst_wr   = ld_inst && (word_cnt == 3'(INST_WORDS - 1));
    assign wb_last   = (wb_cnt == memIndexLen'(WEIGHT_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: next state defaults to the current state so no path leaves it unassigned.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)            state_d = ST_RUN;
            ST_RUN:  if (pe_core_inst_eoc) state_d = ST_WB;
            ST_WB:   if (wb_last)          state_d = ST_DONE;
            ST_DONE:                       state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc                          <= '0;
            inst_ptr                    <= '0;
            data_ptr                    <= '0;
            weight_ptr                  <= '0;
            meta_ptr                    <= '0;
            word_cnt                    <= '0;
            inst_buf                    <= '0;
            wb_cnt                      <= '0;
            mem_wrt_back                <= 1'b0;
            pe_namespace_wrt_done       <= 1'b0;
            pe_namespace_inst_valid     <= 1'b0;
            pe_namespace_data_out_v     <= 1'b0;
            pe_namespace_weight_out_v   <= 1'b0;
            pe_namespace_gradient_out_v <= 1'b0;
            pe_namespace_meta_out_v     <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) pc <= '0;
            else if (pe_core_inst_eol)       pc <= '0;
            else if (fetch)                  pc <= pc + 1'b1;

            // Earlier words shift up so the first word ends up most significant.
            if (inst_wr) begin
                word_cnt <= '0;
                inst_ptr <= inst_ptr + 1'b1;
            end else if (ld_inst) begin
                word_cnt <= word_cnt + 1'b1;
                inst_buf <= {inst_buf[BUF_W-memDataLen-1:0], mem_data_inout};
            end

            if (ld_data)   data_ptr   <= data_ptr + 1'b1;
            if (ld_weight) weight_ptr <= weight_ptr + 1'b1;
            if (ld_meta)   meta_ptr   <= meta_ptr + 1'b1;

            if (state_q != ST_WB) wb_cnt <= '0;
            else if (!wb_last)    wb_cnt <= wb_cnt + 1'b1;

            mem_wrt_back                <= (state_q == ST_WB) && !wb_last;
            pe_namespace_wrt_done       <= (state_q == ST_WB) && wb_last;
            pe_namespace_inst_valid     <= fetch;
            pe_namespace_data_out_v     <= running;
            pe_namespace_weight_out_v   <= running;
            pe_namespace_gradient_out_v <= running;
            pe_namespace_meta_out_v     <= running;
        end
    end

    // The core write port wins; a loader word in the same cycle is lost.
    assign weight_wr_en   = pe_core_weight_wrt || ld_weight;
    assign weight_wr_addr = pe_core_weight_wrt ? pe_core_weight_wrt_addr : weight_ptr;
    assign weight_wr_data = pe_core_weight_wrt ? pe_core_weight_wrt_data : dataLen'(mem_data_inout);
    assign weight_rd_addr = (state_q == ST_WB) ? wb_cnt[weightAddrLen-1:0] : pe_core_weight_rd_addr;

    assign pe_namespace_weight_out = weight_rd_data;
    assign mem_data_inout = mem_wrt_back ? memDataLen'(weight_rd_data) : 'z;

    pe_namespace_ram #(.WIDTH(instLen), .ADDR_W(instAddrLen)) u_inst_mem (
        .clk(clk), .reset(reset),
        .wr_en(inst_wr), .wr_addr(inst_ptr),
        .wr_data({inst_buf, mem_data_inout[LAST_W-1:0]}),
        .rd_en(fetch), .rd_addr(pc), .rd_data(pe_namespace_inst_out)
    );

    pe_namespace_ram #(.WIDTH(dataLen), .ADDR_W(dataAddrLen)) u_data_mem (
        .clk(clk), .reset(reset),
        .wr_en(ld_data), .wr_addr(data_ptr), .wr_data(dataLen'(mem_data_inout)),
        .rd_en(1'b1), .rd_addr(pe_core_data_rd_addr), .rd_data(pe_namespace_data_out)
    );

    pe_namespace_ram #(.WIDTH(dataLen), .ADDR_W(weightAddrLen)) u_weight_mem (
        .clk(clk), .reset(reset),
        .wr_en(weight_wr_en), .wr_addr(weight_wr_addr), .wr_data(weight_wr_data),
        .rd_en(1'b1), .rd_addr(weight_rd_addr), .rd_data(weight_rd_data)
    );

    pe_namespace_ram #(.WIDTH(dataLen), .ADDR_W(weightAddrLen)) u_gradient_mem (
        .clk(clk), .reset(reset),
        .wr_en(pe_core_gradient_wrt), .wr_addr(pe_core_gradient_wrt_addr),
        .wr_data(pe_core_gradient_wrt_data),
        .rd_en(1'b1), .rd_addr(pe_core_gradient_rd_addr), .rd_data(pe_namespace_gradient_out)
    );

    pe_namespace_ram #(.WIDTH(dataLen), .ADDR_W(metaAddrLen)) u_meta_mem (
        .clk(clk), .reset(reset),
        .wr_en(ld_meta), .wr_addr(meta_ptr), .wr_data(dataLen'(mem_data_inout)),
        .rd_en(1'b1), .rd_addr(pe_core_meta_rd_addr), .rd_data(pe_namespace_meta_out)
    );

endmodule

// File: tb/tb_pe_namespace.sv
// Self-checking bench for pe_namespace: directed loads, randomized bus/core
// traffic and fetch/write-back rounds against an array-based reference model.
module tb_pe_namespace;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, start = 1'b0, mem_wrt_valid = 1'b0;
    logic [2:0]  peId_mem_in = '0;
    logic [1:0]  mem_data_type = '0;
    logic [15:0] drv = '0;
    logic        drv_en = 1'b0;
    wire  [15:0] mem_data_inout;
    assign mem_data_inout = drv_en ? drv : 'z;

    logic        eoc = 1'b0, stall = 1'b0, eol = 1'b0;
    logic [4:0]  data_ra = '0, weight_wa = '0, weight_ra = '0, grad_wa = '0, grad_ra = '0;
    logic        weight_wrt = 1'b0, grad_wrt = 1'b0;
    logic [15:0] weight_wd = '0, grad_wd = '0;
    logic [1:0]  meta_ra = '0;

    logic        mem_wrt_back, wrt_done, inst_valid;
    logic [68:0] inst_out;
    logic [15:0] data_out, weight_out, grad_out, meta_out;
    logic        data_v, weight_v, grad_v, meta_v;

    pe_namespace dut (
        .clk(clk), .reset(reset), .start(start), .mem_wrt_valid(mem_wrt_valid),
        .peId_mem_in(peId_mem_in), .mem_data_type(mem_data_type),
        .mem_data_inout(mem_data_inout), .pe_core_inst_eoc(eoc),
        .mem_wrt_back(mem_wrt_back), .pe_namespace_wrt_done(wrt_done),
        .pe_core_inst_stall(stall), .pe_core_inst_eol(eol),
        .pe_core_data_rd_addr(data_ra),
        .pe_core_weight_wrt_addr(weight_wa), .pe_core_weight_wrt(weight_wrt),
        .pe_core_weight_wrt_data(weight_wd), .pe_core_weight_rd_addr(weight_ra),
        .pe_core_gradient_wrt_addr(grad_wa), .pe_core_gradient_wrt(grad_wrt),
        .pe_core_gradient_wrt_data(grad_wd), .pe_core_gradient_rd_addr(grad_ra),
        .pe_core_meta_rd_addr(meta_ra),
        .pe_namespace_inst_out(inst_out), .pe_namespace_inst_valid(inst_valid),
        .pe_namespace_data_out(data_out), .pe_namespace_data_out_v(data_v),
        .pe_namespace_weight_out(weight_out), .pe_namespace_weight_out_v(weight_v),
        .pe_namespace_gradient_out(grad_out), .pe_namespace_gradient_out_v(grad_v),
        .pe_namespace_meta_out(meta_out), .pe_namespace_meta_out_v(meta_v)
    );

    // Reference model: plain arrays plus "written" flags for known contents.
    logic [68:0] imem_m [DEPTH];
    bit          imem_k [DEPTH];
    logic [15:0] dmem_m [DEPTH], wmem_m [DEPTH], gmem_m [DEPTH], meta_m [4];
    bit          dmem_k [DEPTH], wmem_k [DEPTH], gmem_k [DEPTH], meta_k [4];
    int          iptr, dptr, wptr, mptr, m_pc;
    logic [15:0] iq [$];
    logic [68:0] last_out;
    bit          last_k;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        iptr = 0; dptr = 0; wptr = 0; mptr = 0;
        iq.delete();
        last_out = '0;
        last_k = 1'b1;
    endtask

    task automatic model_load(input int t, input logic [15:0] w, input bit core_wwrt);
        logic [15:0] w4;
        case (t)
            0: begin
                iq.push_back(w);
                if (iq.size() == 5) begin
                    w4 = iq[4];
                    imem_m[iptr] = {iq[0], iq[1], iq[2], iq[3], w4[4:0]};
                    imem_k[iptr] = 1'b1;
                    iptr = (iptr + 1) % DEPTH;
                    iq.delete();
                end
            end
            1: begin dmem_m[dptr] = w; dmem_k[dptr] = 1'b1; dptr = (dptr + 1) % DEPTH; end
            2: begin
                if (!core_wwrt) begin wmem_m[wptr] = w; wmem_k[wptr] = 1'b1; end
                wptr = (wptr + 1) % DEPTH;
            end
            default: begin meta_m[mptr] = w; meta_k[mptr] = 1'b1; mptr = (mptr + 1) % 4; end
        endcase
    endtask

    task automatic load_word(input int t, input logic [2:0] pe, input logic [15:0] w, input bit core_wwrt);
        mem_wrt_valid = 1'b1; peId_mem_in = pe; mem_data_type = 2'(t); drv = w; drv_en = 1'b1;
        tick();
        mem_wrt_valid = 1'b0; drv_en = 1'b0;
        if (pe == 3'd0) model_load(t, w, core_wwrt);
    endtask

    task automatic read_all(input logic [4:0] a);
        data_ra = a; weight_ra = a; grad_ra = a; meta_ra = a[1:0];
        tick();
        if (dmem_k[a])      check("rd_data", data_out, dmem_m[a]);
        if (wmem_k[a])      check("rd_weight", weight_out, wmem_m[a]);
        if (gmem_k[a])      check("rd_gradient", grad_out, gmem_m[a]);
        if (meta_k[a[1:0]]) check("rd_meta", meta_out, meta_m[a[1:0]]);
    endtask

    task automatic fetch_loop(input int cycles);
        bit st, el;
        for (int c = 0; c < cycles; c++) begin
            st = ($urandom_range(0, 4) == 0);
            el = (m_pc == 2);
            stall = st; eol = el;
            tick();
            if (st) begin
                check("fetch_stall_valid", inst_valid, 0);
                if (last_k) check("fetch_hold", inst_out, last_out);
            end else begin
                check("fetch_valid", inst_valid, 1);
                if (imem_k[m_pc]) check("fetch_inst", inst_out, imem_m[m_pc]);
                last_out = imem_m[m_pc];
                last_k = imem_k[m_pc];
                m_pc++;
            end
            if (el) m_pc = 0;
            check("run_data_v", data_v, 1);
        end
        stall = 1'b0; eol = 1'b0;
    endtask

    task automatic run_wb();
        stall = 1'b1; eoc = 1'b1;
        tick();
        stall = 1'b0; eoc = 1'b0;
        check("wb_gap", mem_wrt_back, 0);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            check("wb_active", mem_wrt_back, 1);
            if (wmem_k[i]) check("wb_word", mem_data_inout, wmem_m[i]);
        end
        tick();
        check("wb_release", mem_wrt_back, 0);
        check("wb_done", wrt_done, 1);
        tick();
        check("wb_done_pulse", wrt_done, 0);
    endtask

    initial begin
        logic [15:0] plan1 [5];
        logic [15:0] plan2 [5];
        plan1 = '{16'h0000, 16'h4010, 16'h0000, 16'h0000, 16'h000A};
        plan2 = '{16'h0800, 16'h4050, 16'h0000, 16'h0080, 16'h0002};
        model_reset();
        tick(); tick();
        reset = 1'b0;
        check("rst_inst_out", inst_out, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_weight_out", weight_out, 0);
        check("rst_out_v", {data_v, weight_v, grad_v, meta_v}, 0);
        check("rst_wrt_back", mem_wrt_back, 0);
        check("rst_wrt_done", wrt_done, 0);

        // Directed loads, including words addressed to another PE.
        load_word(1, 3'd1, 16'hBEEF, 1'b0);
        for (int i = 0; i < 5; i++) load_word(0, 3'd0, plan1[i], 1'b0);
        for (int i = 0; i < 5; i++) begin
            load_word(0, 3'd0, plan2[i], 1'b0);
            if (i == 2) load_word(0, 3'd2, 16'hFFFF, 1'b0);
        end
        for (int i = 0; i < 5; i++) load_word(0, 3'd0, 16'($urandom), 1'b0);
        load_word(1, 3'd0, 16'h0012, 1'b0);
        load_word(1, 3'd0, 16'h0056, 1'b0);
        load_word(2, 3'd0, 16'h0034, 1'b0);
        load_word(2, 3'd0, 16'h0078, 1'b0);
        load_word(2, 3'd0, 16'h009A, 1'b0);
        load_word(3, 3'd0, 16'h0012, 1'b0);

        // Core weight/gradient write colliding with a loader weight word.
        weight_wrt = 1'b1; weight_wa = 5'hD; weight_wd = 16'h00DD;
        grad_wrt = 1'b1; grad_wa = 5'hD; grad_wd = 16'h00DD;
        load_word(2, 3'd0, 16'h00EE, 1'b1);
        weight_wrt = 1'b0; grad_wrt = 1'b0;
        wmem_m[13] = 16'h00DD; wmem_k[13] = 1'b1;
        gmem_m[13] = 16'h00DD; gmem_k[13] = 1'b1;

        read_all(5'd0);
        check("plan_data0", data_out, 16'h0012);
        check("plan_meta0", meta_out, 16'h0012);
        check("idle_out_v", {data_v, weight_v, grad_v, meta_v}, 0);
        read_all(5'd1);
        check("plan_data1", data_out, 16'h0056);
        read_all(5'd2);
        check("plan_weight2", weight_out, 16'h009A);
        read_all(5'd13);
        check("plan_weight_collide", weight_out, 16'h00DD);
        check("plan_gradient", grad_out, 16'h00DD);

        // First fetch round.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_edge_valid", inst_valid, 0);
        tick();
        check("first_inst", inst_out, 69'h802000000000A);
        check("first_valid", inst_valid, 1);
        last_out = imem_m[0]; last_k = imem_k[0]; m_pc = 1;
        fetch_loop(20);
        run_wb();

        // Reset in the middle of write-back releases the bus.
        start = 1'b1;
        tick();
        start = 1'b0;
        stall = 1'b1; eoc = 1'b1;
        tick();
        eoc = 1'b0; stall = 1'b0;
        tick(); tick();
        check("midwb_active", mem_wrt_back, 1);
        reset = 1'b1;
        tick();
        check("midwb_release", mem_wrt_back, 0);
        reset = 1'b0;
        model_reset();

        // Randomized loader plus core traffic, read-first checked every cycle.
        for (int n = 0; n < 400; n++) begin
            int t;
            logic [2:0] pe;
            logic [15:0] w, ed, ew, eg, em;
            bit v, kd, kw, kg, km;
            t  = $urandom_range(0, 3);
            pe = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            w  = 16'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            mem_wrt_valid = v; peId_mem_in = pe; mem_data_type = 2'(t); drv = w; drv_en = 1'b1;
            weight_wrt = ($urandom_range(0, 3) == 0);
            weight_wa = 5'($urandom_range(0, 31)); weight_wd = 16'($urandom);
            grad_wrt = ($urandom_range(0, 2) == 0);
            grad_wa = 5'($urandom_range(0, 31)); grad_wd = 16'($urandom);
            data_ra = 5'($urandom_range(0, 31)); weight_ra = 5'($urandom_range(0, 31));
            grad_ra = 5'($urandom_range(0, 31)); meta_ra = 2'($urandom_range(0, 3));
            ed = dmem_m[data_ra];  kd = dmem_k[data_ra];
            ew = wmem_m[weight_ra]; kw = wmem_k[weight_ra];
            eg = gmem_m[grad_ra];  kg = gmem_k[grad_ra];
            em = meta_m[meta_ra];  km = meta_k[meta_ra];
            tick();
            if (kd) check("rnd_data", data_out, ed);
            if (kw) check("rnd_weight", weight_out, ew);
            if (kg) check("rnd_gradient", grad_out, eg);
            if (km) check("rnd_meta", meta_out, em);
            if (weight_wrt) begin wmem_m[weight_wa] = weight_wd; wmem_k[weight_wa] = 1'b1; end
            if (grad_wrt) begin gmem_m[grad_wa] = grad_wd; gmem_k[grad_wa] = 1'b1; end
            if (v && pe == 3'd0) model_load(t, w, weight_wrt);
        end
        mem_wrt_valid = 1'b0; drv_en = 1'b0; weight_wrt = 1'b0; grad_wrt = 1'b0;
        for (int a = 0; a < DEPTH; a++) read_all(5'(a));

        // Second fetch and write-back round on the randomized contents.
        start = 1'b1;
        tick();
        start = 1'b0;
        m_pc = 0;
        fetch_loop(24);
        run_wb();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
